ray_dir_gen: RTL and testbench
==============================

RAY_DIR_GEN -- requirements
Module: ray_dir_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 64, image width in pixels (>=2, even).
REQ-002 SHALL have parameter IMG_H, default 48, image height in pixels (>=2, even).
REQ-003 SHALL have parameter PIX_STEP, default 32'sh0000_0400, Q16.16 per-pixel direction increment.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse; begins a frame when idle.
REQ-007 SHALL have port out_valid  output  1  direction vector available.
REQ-008 SHALL have port out_ready  input  1  downstream (normalizer) accepts vector.
REQ-009 SHALL have port dir_x, dir_y, dir_z  output  32 each  signed Q16.16 unnormalized ray direction.
REQ-010 SHALL have port px  output  $clog2(IMG_W)  pixel column of current vector.
REQ-011 SHALL have port py  output  $clog2(IMG_H)  pixel row of current vector.
REQ-012 SHALL have port last  output  1  high with the final pixel of a frame.
REQ-013 SHALL have port busy  output  1  high in RUN state.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE.
REQ-015 IDLE: start=1 -> RUN with px=0, py=0; start ignored in RUN.
REQ-016 out_valid SHALL rise exactly one cycle after RUN entry and after each accepted transfer (registered outputs, latency 1).
REQ-017 Transfer occurs when out_valid && out_ready; dir_*, px, py, last SHALL be held stable while out_valid && !out_ready.
REQ-018 On transfer: px increments; px=IMG_W-1 wraps to 0 and py increments.
REQ-019 dir_x SHALL equal (px - IMG_W/2) * PIX_STEP, computed as signed 32-bit, wrapping on overflow.
REQ-020 dir_y SHALL equal (IMG_H/2 - py) * PIX_STEP, signed 32-bit, wrapping.
REQ-021 dir_z SHALL equal constant -1.0 (32'shFFFF_0000).
REQ-022 last SHALL be 1 only when px=IMG_W-1 and py=IMG_H-1.
REQ-023 Transfer with last=1 SHALL enter DONE; out_valid low from next cycle.
REQ-024 DONE: start=1 -> RUN (new frame from 0,0); otherwise remain DONE.
REQ-025 No multipliers by variable beyond coordinate x constant; implementation MAY use incremental add of PIX_STEP but results SHALL be bit-identical to REQ-019/020.
REQ-026 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-027 rst_n=0 SHALL asynchronously force state IDLE, out_valid=0, last=0, busy=0, px=0, py=0, dir_x=dir_y=dir_z=0.
REQ-028 Reset mid-frame SHALL discard the frame; no vector emitted until next start after release.
REQ-029 Reset release SHALL be synchronous to clk edge (no output change in release cycle).

Configuration
REQ-030 Macro RAY_DIR_GEN_FRAME_LOOP_EN defined: transfer with last=1 SHALL return to (0,0) in RUN and continue streaming without start; DONE unreachable.
REQ-031 Macro undefined: behaviour per REQ-023/024.

Structure
REQ-032 Package ray_pkg SHALL hold Q16_ONE, Q16_NEG_ONE, and the state enum typedef raygen_state_t.
REQ-033 Pixel scan counters SHALL be one sub-module ray_pix_counter (advance, wrap, last flag); arithmetic and handshake remain in ray_dir_gen.

Verification (IMG_W=4, IMG_H=2, PIX_STEP=32'sh0000_8000)
REQ-034 start pulse, out_ready=1 -> first vector px=0,py=0, dir_x=FFFF0000, dir_y=00008000, dir_z=FFFF0000, valid one cycle after RUN.
REQ-035 out_ready=1 continuous -> 8 transfers in 8 consecutive cycles; last vector px=3,py=1, dir_x=00008000, dir_y=00000000, last=1; then out_valid=0, state DONE.
REQ-036 out_ready=0 for 5 cycles at px=2 -> outputs unchanged all 5 cycles, no skipped/duplicated pixel after release.
REQ-037 rst_n low during px=1,py=1 -> all outputs 0 immediately; start after release restarts at (0,0).
REQ-038 start asserted during RUN -> ignored, sequence unaffected; with RAY_DIR_GEN_FRAME_LOOP_EN, pixel 9 is (0,0) with no start.

Source files
------------

// File: rtl/ray_pkg.sv
// rtl/ray_pkg.sv - shared Q16.16 constants, state type and scaling helper for ray_dir_gen
package ray_pkg;

    localparam logic signed [31:0] Q16_ONE     = 32'sh0001_0000;
    localparam logic signed [31:0] Q16_NEG_ONE = -Q16_ONE;

    typedef enum logic [1:0] {
        RG_IDLE = 2'd0,
        RG_RUN  = 2'd1,
        RG_DONE = 2'd2
    } raygen_state_t;

    // Elaboration-time coordinate x step product, wrapping to 32 bits.
    function automatic logic signed [31:0] q16_scale(input int coord, input logic signed [31:0] step);
        return 32'(coord * step);
    endfunction

endpackage

// File: rtl/ray_pix_counter.sv
// rtl/ray_pix_counter.sv - raster scan column/row counter with row-end and frame-last flags
module ray_pix_counter #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 48,
    parameter int XW    = $clog2(IMG_W),
    parameter int YW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          advance,
    output logic [XW-1:0] px,
    output logic [YW-1:0] py,
    output logic          row_end,
    output logic          last
);

    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

    assign row_end = (px == X_MAX);
    assign last    = row_end && (py == Y_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px <= '0;
            py <= '0;
        end else if (clear) begin
            px <= '0;
            py <= '0;
        end else if (advance) begin
            if (row_end) begin
                px <= '0;
                py <= last ? '0 : py + YW'(1);
            end else begin
                px <= px + XW'(1);
            end
        end
    end

endmodule

// File: rtl/ray_dir_gen.sv
// rtl/ray_dir_gen.sv - per-pixel unnormalized Q16.16 camera ray direction streamer
// Optional feature: RAY_DIR_GEN_FRAME_LOOP_EN restarts the scan at (0,0) after the last pixel.
module ray_dir_gen
    import ray_pkg::*;
#(
    parameter int                 IMG_W    = 64,
    parameter int                 IMG_H    = 48,
    parameter logic signed [31:0] PIX_STEP = 32'sh0000_0400
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              dir_x,
    output logic [31:0]              dir_y,
    output logic [31:0]              dir_z,
    output logic [$clog2(IMG_W)-1:0] px,
    output logic [$clog2(IMG_H)-1:0] py,
    output logic                     last,
    output logic                     busy
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    // Direction at column 0 / row 0; later pixels are reached by adding or subtracting PIX_STEP.
    localparam logic signed [31:0] DIR_X0 = q16_scale(-(IMG_W / 2), PIX_STEP);
    localparam logic signed [31:0] DIR_Y0 = q16_scale(IMG_H / 2, PIX_STEP);

    raygen_state_t state_q, state_d;
    logic          cnt_clear;
    logic          xfer;
    logic          row_end;

    assign xfer = out_valid && out_ready;
    assign busy = (state_q == RG_RUN);

    ray_pix_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .XW    (XW),
        .YW    (YW)
    ) u_pix_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .advance (xfer),
        .px      (px),
        .py      (py),
        .row_end (row_end),
        .last    (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        case (state_q)
            RG_IDLE, RG_DONE: begin
                if (start) begin
                    state_d   = RG_RUN;
                    cnt_clear = 1'b1;
                end
            end
            RG_RUN: begin
`ifdef RAY_DIR_GEN_FRAME_LOOP_EN
                state_d = RG_RUN;
`else
                if (xfer && last) begin
                    state_d = RG_DONE;
                end
`endif
            end
            default: state_d = RG_IDLE;
        endcase
    end

    // First RUN cycle loads the (0,0) vector; each transfer loads the next pixel's vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dir_x     <= '0;
            dir_y     <= '0;
            dir_z     <= '0;
        end else if (state_q == RG_RUN) begin
            if (!out_valid) begin
                out_valid <= 1'b1;
                dir_x     <= DIR_X0;
                dir_y     <= DIR_Y0;
                dir_z     <= Q16_NEG_ONE;
            end else if (xfer) begin
                if (row_end) begin
                    dir_x <= DIR_X0;
                    dir_y <= last ? DIR_Y0 : dir_y - PIX_STEP;
                end else begin
                    dir_x <= dir_x + PIX_STEP;
                end
`ifdef RAY_DIR_GEN_FRAME_LOOP_EN
                out_valid <= 1'b1;
`else
                if (last) begin
                    out_valid <= 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_ray_dir_gen.sv
// tb/tb_ray_dir_gen.sv - randomized self-checking bench for ray_dir_gen (4x2 image, step 0.5)
module tb_ray_dir_gen;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;
    localparam int STEP = 32'sh0000_8000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dir_x, dir_y, dir_z;
    logic [1:0]  px;
    logic [0:0]  py;
    logic        last;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    ray_dir_gen #(
        .IMG_W    (W),
        .IMG_H    (H),
        .PIX_STEP (32'sh0000_8000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dir_x     (dir_x),
        .dir_y     (dir_y),
        .dir_z     (dir_z),
        .px        (px),
        .py        (py),
        .last      (last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: pixel i of a raster scan and its direction straight from the coordinates.
    function automatic int exp_px(input int i);
        return i % W;
    endfunction
    function automatic int exp_py(input int i);
        return i / W;
    endfunction
    function automatic int exp_dx(input int i);
        return (exp_px(i) - W / 2) * STEP;
    endfunction
    function automatic int exp_dy(input int i);
        return (H / 2 - exp_py(i)) * STEP;
    endfunction

    task automatic begin_frame();
        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_entry", 32'(busy), 32'd1);
        check("valid_entry", 32'(out_valid), 32'd0);
    endtask

    task automatic run_frame(input int rdy_pct, input bit stall, input bit poke, output int cycles);
        int idx        = 0;
        int cyc        = 0;
        int stall_left = stall ? 5 : 0;
        while (idx < NPIX && cyc < 400) begin
            @(posedge clk); #1;
            if (stall && idx == 2 && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(0, 99) < rdy_pct);
            end
            start = poke && (cyc == 3);
            @(negedge clk);
            if (cyc == 0) check("valid_lat1", 32'(out_valid), 32'd1);
            if (out_valid) begin
                check("px", 32'(px), 32'(exp_px(idx)));
                check("py", 32'(py), 32'(exp_py(idx)));
                check("dir_x", dir_x, 32'(exp_dx(idx)));
                check("dir_y", dir_y, 32'(exp_dy(idx)));
                check("dir_z", dir_z, 32'hFFFF_0000);
                check("last", 32'(last), 32'(idx == NPIX - 1));
                if (out_ready) idx++;
            end
            cyc++;
        end
        start = 1'b0;
        if (idx != NPIX) check("frame_timeout", 32'(idx), 32'(NPIX));
        if (stall) check("stall_len", 32'(stall_left), 32'd0);
        cycles = cyc;
    endtask

    task automatic end_check();
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
`ifdef RAY_DIR_GEN_FRAME_LOOP_EN
        check("loop_valid", 32'(out_valid), 32'd1);
        check("loop_px", 32'(px), 32'd0);
        check("loop_py", 32'(py), 32'd0);
        check("loop_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
`else
        check("done_valid", 32'(out_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("done_stays", 32'(out_valid), 32'd0);
`endif
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_last"}, 32'(last), 32'd0);
        check({tag, "_px"}, 32'(px), 32'd0);
        check({tag, "_py"}, 32'(py), 32'd0);
        check({tag, "_dx"}, dir_x, 32'd0);
        check({tag, "_dy"}, dir_y, 32'd0);
        check({tag, "_dz"}, dir_z, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c;
        bit  found;
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_valid", 32'(out_valid), 32'd0);

        begin_frame();
        run_frame(100, 1'b0, 1'b0, c);
        check("burst_cycles", 32'(c), 32'(NPIX));
        end_check();

        begin_frame();
        run_frame(60, 1'b1, 1'b0, c);
        end_check();

        begin_frame();
        run_frame(100, 1'b0, 1'b1, c);
        end_check();

        for (int f = 0; f < 4; f++) begin
            begin_frame();
            run_frame(int'($urandom_range(30, 100)), 1'b0, f[0], c);
            end_check();
        end

        begin_frame();
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
            if (out_valid && px == 2'd1 && py == 1'b1) found = 1'b1;
        end
        check("find_p11", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_emit_rst", 32'(out_valid), 32'd0);
        end

        begin_frame();
        run_frame(100, 1'b0, 1'b0, c);
        check("restart_cycles", 32'(c), 32'(NPIX));
        end_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
